spc7110_psram_arb: RTL and testbench
====================================

Name: spc7110_psram_arb

Overview:
- Single-port PSRAM arbiter for the SPC7110 cartridge build.
- Shares the 16-bit PSRAM bus between three requesters:
  - the SNES-triggered data-ROM MMIO port (from the direct-access block's direct_rom_rd / psram_addr);
  - the decompression unit (DCU) fetch port;
  - the MCU read/write port (save RAM, uploads).
- Sequences each access through a fixed-length PSRAM cycle, returns read data to the winner and pulses its ack.

Parameters:
- ACCESS_CYCLES, 4, CLK cycles that oe_n/we_n stay asserted per access (legal 1..15).
- ADDR_W, 23, PSRAM word-address width.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- snes_req  in  1  level; high while the direct port owns a read (direct_rom_rd)
- snes_addr  in  ADDR_W  direct-port word address
- snes_rdata  out  16  last word read for the direct port
- snes_ack  out  1  one-cycle pulse when snes_rdata is updated
- dcu_req  in  1  held high until dcu_ack
- dcu_addr  in  ADDR_W  DCU word address
- dcu_rdata  out  16  DCU read data
- dcu_ack  out  1  one-cycle completion pulse
- mcu_req  in  1  held high until mcu_ack
- mcu_we  in  1  1 = write, 0 = read; sampled at grant
- mcu_addr  in  ADDR_W  MCU word address
- mcu_wdata  in  16  MCU write data
- mcu_rdata  out  16  MCU read data
- mcu_ack  out  1  one-cycle completion pulse
- psram_addr  out  ADDR_W  PSRAM address
- psram_wdata  out  16  PSRAM write data
- psram_rdata  in  16  PSRAM read data
- psram_ce_n  out  1  chip enable, active low
- psram_oe_n  out  1  output enable, active low
- psram_we_n  out  1  write enable, active low
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: ce_n/oe_n/we_n = 1; addr, wdata and all rdata = 0; acks = 0; busy = 0; state IDLE; snes_pend = 0. Reset is asynchronous: strobes deassert immediately, including mid-access, and the access in flight is dropped with no ack.
- SNES trigger: snes_pend sets on a rising edge of snes_req, or on a snes_addr change while snes_req = 1 (registered compare of snes_addr). It clears when the SNES access is granted.
- Priority, evaluated in IDLE only: snes_pend > mcu_req > dcu_req. There is no preemption; an access in flight always completes.
- FSM:
  - IDLE: on a winner, latch the requester id, address, we and wdata; go to SETUP.
  - SETUP (1 cycle): ce_n = 0; address/wdata stable.
  - ACCESS (ACCESS_CYCLES cycles): ce_n = 0; oe_n = 0 for a read, we_n = 0 for a write. Down-counter loaded with ACCESS_CYCLES-1.
  - DONE (1 cycle): all strobes high. For a read, psram_rdata is captured into the winner's rdata on the ACCESS→DONE edge. Winner's ack pulses during DONE. Next state IDLE.
- Latency from grant to ack: ACCESS_CYCLES+2 cycles. Worst-case SNES latency: 2*(ACCESS_CYCLES+3) cycles.
- Simultaneous events:
  - SNES trigger during any other requester's access: pended, served next.
  - SNES retrigger while its own access is in flight: pended again, re-served with the new address.
  - snes_req falling while an access is pended: the pend is kept, the read completes, and the result is discarded by the consumer.
- Requesters holding req after their ack are treated as new requests.
- rdata registers hold their value until that requester's next read completes.

Optional Feature:
- Macro SPC7110_ARB_STARVE_GUARD_EN.
- Defined: 4-bit counter counts DCU grants lost to the MCU while dcu_req is high. When the count reaches 8, the DCU outranks the MCU (never the SNES) for one grant; the counter clears on each DCU grant.
- Undefined: fixed priority only; the DCU can starve under continuous MCU traffic.

Decomposition:
- Shared package spc7110_pkg holds:
  - requester id enum (REQ_NONE, REQ_SNES, REQ_MCU, REQ_DCU);
  - FSM state encoding;
  - DATA_ROM_BASE constant (24'h100000 byte offset, shared with the direct-access block).
- One sub-module, spc7110_arb_prio: combinational priority picker, including the guard logic. The FSM stays in the top.

Test Plan:
- Reset, then MCU write addr 0x000010 data 0xBEEF, then MCU read → mcu_rdata = 0xBEEF; mcu_ack pulses 6 cycles after each grant (ACCESS_CYCLES = 4); we_n low exactly 4 cycles.
- dcu_req and snes_req rise in the same cycle, addr 0x080000 / 0x080100 → SNES served first, DCU second; snes_ack precedes dcu_ack by 7 cycles.
- DCU access in flight; snes_req rises at the 2nd ACCESS cycle → DCU completes without glitch; SNES grant follows in the next IDLE; snes_ack within 14 cycles of the trigger.
- snes_req held high, snes_addr steps 0x080000 → 0x080001 → 0x080002 → exactly 3 snes_ack pulses, rdata matching the model memory.
- RESET asserted during ACCESS of an MCU write → strobes high in the same cycle, no mcu_ack, busy = 0; a subsequent request completes normally.
- With SPC7110_ARB_STARVE_GUARD_EN: MCU requests continuously, DCU pending → DCU granted after 8 MCU grants. Without the macro → no DCU grant while MCU is active.

Source files
------------

// File: rtl/spc7110_pkg.sv
// spc7110_pkg: requester ids, arbiter FSM encoding and shared constants
// for the SPC7110 PSRAM arbiter and the direct-access block.
package spc7110_pkg;
   typedef enum logic [1:0] {REQ_NONE, REQ_SNES, REQ_MCU, REQ_DCU} req_id_t;
   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} arb_state_t;
   localparam logic [23:0] DATA_ROM_BASE = 24'h100000;
   localparam int STARVE_LIMIT = 8;
endpackage

// File: rtl/spc7110_arb_prio.sv
// spc7110_arb_prio: combinational grant picker, SNES > MCU > DCU.
// SPC7110_ARB_STARVE_GUARD_EN lets a DCU starved by the MCU win one grant.
module spc7110_arb_prio
   import spc7110_pkg::*;
(
   input  logic       snes_pend_i,
   input  logic       mcu_req_i,
   input  logic       dcu_req_i,
   input  logic [3:0] starve_q_i,
   output req_id_t    win_o,
   output logic [3:0] starve_d_o
);
`ifdef SPC7110_ARB_STARVE_GUARD_EN
   logic dcu_boost;
   assign dcu_boost = dcu_req_i && starve_q_i >= 4'(STARVE_LIMIT);
   always_comb begin
      win_o      = snes_pend_i ? REQ_SNES : dcu_boost ? REQ_DCU : mcu_req_i ? REQ_MCU :
                   dcu_req_i ? REQ_DCU : REQ_NONE;
      starve_d_o = win_o == REQ_DCU ? 4'd0 :
                   (win_o == REQ_MCU && dcu_req_i) ? starve_q_i + 4'd1 : starve_q_i;
   end
`else
   logic unused_starve;
   assign unused_starve = ^starve_q_i;
   assign win_o      = snes_pend_i ? REQ_SNES : mcu_req_i ? REQ_MCU :
                       dcu_req_i ? REQ_DCU : REQ_NONE;
   assign starve_d_o = 4'd0;
`endif
endmodule

// File: rtl/spc7110_psram_arb.sv
// spc7110_psram_arb: shares the 16-bit PSRAM between SNES direct port, MCU and DCU.
// Optional DCU starvation guard: SPC7110_ARB_STARVE_GUARD_EN.
module spc7110_psram_arb
   import spc7110_pkg::*;
#(
   parameter int ACCESS_CYCLES = 4,
   parameter int ADDR_W        = 23
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              snes_req,
   input  logic [ADDR_W-1:0] snes_addr,
   output logic [15:0]       snes_rdata,
   output logic              snes_ack,
   input  logic              dcu_req,
   input  logic [ADDR_W-1:0] dcu_addr,
   output logic [15:0]       dcu_rdata,
   output logic              dcu_ack,
   input  logic              mcu_req,
   input  logic              mcu_we,
   input  logic [ADDR_W-1:0] mcu_addr,
   input  logic [15:0]       mcu_wdata,
   output logic [15:0]       mcu_rdata,
   output logic              mcu_ack,
   output logic [ADDR_W-1:0] psram_addr,
   output logic [15:0]       psram_wdata,
   input  logic [15:0]       psram_rdata,
   output logic              psram_ce_n,
   output logic              psram_oe_n,
   output logic              psram_we_n,
   output logic              busy
);
   arb_state_t        state_q, state_d;
   req_id_t           id_q, id_d, win;
   logic [ADDR_W-1:0] addr_q, addr_d, snes_addr_q;
   logic [15:0]       wdata_q, wdata_d, snes_rdata_q, dcu_rdata_q, mcu_rdata_q;
   logic [3:0]        cnt_q, cnt_d, starve_q, starve_d, starve_nx;
   logic              we_q, we_d, pend_q, pend_d, snes_req_q;
   logic              snes_trig, pend_any, last_beat, rd_done;

   // A new address while the direct port stays up is a fresh read.
   assign snes_trig = snes_req && (!snes_req_q || snes_addr != snes_addr_q);
   assign pend_any  = pend_q || snes_trig;
   assign last_beat = state_q == ST_ACCESS && cnt_q == 4'd0;
   assign rd_done   = last_beat && !we_q;

   spc7110_arb_prio u_prio (
      .snes_pend_i(pend_any),
      .mcu_req_i  (mcu_req),
      .dcu_req_i  (dcu_req),
      .starve_q_i (starve_q),
      .win_o      (win),
      .starve_d_o (starve_d)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      id_d      = id_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      pend_d    = pend_any;
      starve_nx = starve_q;
      case (state_q)
         ST_IDLE: if (win != REQ_NONE) begin
            state_d   = ST_SETUP;
            id_d      = win;
            addr_d    = win == REQ_SNES ? snes_addr : win == REQ_MCU ? mcu_addr : dcu_addr;
            we_d      = win == REQ_MCU && mcu_we;
            wdata_d   = mcu_wdata;
            pend_d    = pend_any && win != REQ_SNES;
            starve_nx = starve_d;
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            cnt_d   = 4'(ACCESS_CYCLES - 1);
         end
         ST_ACCESS: begin
            state_d = last_beat ? ST_DONE : ST_ACCESS;
            cnt_d   = last_beat ? cnt_q : cnt_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         id_q         <= REQ_NONE;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         pend_q       <= 1'b0;
         starve_q     <= '0;
         snes_req_q   <= 1'b0;
         snes_addr_q  <= '0;
         snes_rdata_q <= '0;
         dcu_rdata_q  <= '0;
         mcu_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         id_q         <= id_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         pend_q       <= pend_d;
         starve_q     <= starve_nx;
         snes_req_q   <= snes_req;
         snes_addr_q  <= snes_addr;
         snes_rdata_q <= rd_done && id_q == REQ_SNES ? psram_rdata : snes_rdata_q;
         dcu_rdata_q  <= rd_done && id_q == REQ_DCU ? psram_rdata : dcu_rdata_q;
         mcu_rdata_q  <= rd_done && id_q == REQ_MCU ? psram_rdata : mcu_rdata_q;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign psram_ce_n  = !(state_q == ST_SETUP || state_q == ST_ACCESS);
   assign psram_oe_n  = !(state_q == ST_ACCESS && !we_q);
   assign psram_we_n  = !(state_q == ST_ACCESS && we_q);
   assign psram_addr  = addr_q;
   assign psram_wdata = wdata_q;
   assign busy        = state_q != ST_IDLE;
   assign snes_ack    = state_q == ST_DONE && id_q == REQ_SNES;
   assign dcu_ack     = state_q == ST_DONE && id_q == REQ_DCU;
   assign mcu_ack     = state_q == ST_DONE && id_q == REQ_MCU;
   assign snes_rdata  = snes_rdata_q;
   assign dcu_rdata   = dcu_rdata_q;
   assign mcu_rdata   = mcu_rdata_q;
endmodule

// File: tb/tb_spc7110_psram_arb.sv
// tb_spc7110_psram_arb: transaction-level model of the arbiter plus directed scenarios.
module tb_spc7110_psram_arb;
   localparam int A  = 4;
   localparam int AW = 23;
`ifdef SPC7110_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          CLK = 1'b0, RESET = 1'b0;
   logic          snes_req = 1'b0, dcu_req = 1'b0, mcu_req = 1'b0, mcu_we = 1'b0;
   logic [AW-1:0] snes_addr = '0, dcu_addr = '0, mcu_addr = '0;
   logic [15:0]   mcu_wdata = '0;
   logic [15:0]   snes_rdata, dcu_rdata, mcu_rdata, psram_wdata, psram_rdata;
   logic          snes_ack, dcu_ack, mcu_ack, psram_ce_n, psram_oe_n, psram_we_n, busy;
   logic [AW-1:0] psram_addr;

   always #5 CLK = ~CLK;

   spc7110_psram_arb #(.ACCESS_CYCLES(A), .ADDR_W(AW)) dut (
      .CLK(CLK), .RESET(RESET),
      .snes_req(snes_req), .snes_addr(snes_addr), .snes_rdata(snes_rdata), .snes_ack(snes_ack),
      .dcu_req(dcu_req), .dcu_addr(dcu_addr), .dcu_rdata(dcu_rdata), .dcu_ack(dcu_ack),
      .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
      .mcu_rdata(mcu_rdata), .mcu_ack(mcu_ack),
      .psram_addr(psram_addr), .psram_wdata(psram_wdata), .psram_rdata(psram_rdata),
      .psram_ce_n(psram_ce_n), .psram_oe_n(psram_oe_n), .psram_we_n(psram_we_n), .busy(busy)
   );

   function automatic int idx(input logic [AW-1:0] a);
      return int'(a[11:0] ^ {1'b0, a[22:12]});
   endfunction

   // PSRAM device: combinational read, write on each clock while we_n is low.
   logic [15:0] pmem [0:4095];
   assign psram_rdata = pmem[idx(psram_addr)];
   initial begin
      for (int i = 0; i < 4096; i++) pmem[i] = 16'(32'hA000 | i);
      forever begin
         @(posedge CLK);
         if (!psram_ce_n && !psram_we_n) pmem[idx(psram_addr)] = psram_wdata;
      end
   end

   // Model: m_t = cycles since grant (0 idle, 1 setup, 2..A+1 strobe, A+2 ack).
   int            m_t, m_id, m_starve;
   logic [AW-1:0] m_addr, p_addr;
   logic          m_we, m_pend, p_req;
   logic [15:0]   m_wdata;
   logic [15:0]   m_rd [1:3];
   logic [15:0]   rmem [0:4095];
   initial begin
      logic trig;
      int   w;
      for (int i = 0; i < 4096; i++) rmem[i] = 16'(32'hA000 | i);
      forever begin
         if (RESET || $time == 0) begin
            m_t = 0; m_id = 0; m_starve = 0; m_addr = '0; p_addr = '0;
            m_we = 0; m_pend = 0; p_req = 0; m_wdata = '0;
            m_rd[1] = '0; m_rd[2] = '0; m_rd[3] = '0;
         end else begin
            trig   = snes_req && (!p_req || snes_addr != p_addr);
            p_req  = snes_req;
            p_addr = snes_addr;
            m_pend = m_pend || trig;
            if (m_t == A + 2) m_t = 0;
            else if (m_t > 0) begin
               m_t++;
               if (m_t == A + 2) begin
                  if (m_we) rmem[idx(m_addr)] = m_wdata;
                  else m_rd[m_id] = rmem[idx(m_addr)];
               end
            end else begin
               w = m_pend ? 1 : (GUARD && dcu_req && m_starve >= 8) ? 3 :
                   mcu_req ? 2 : dcu_req ? 3 : 0;
               if (w != 0) begin
                  m_t     = 1;
                  m_id    = w;
                  m_addr  = w == 1 ? snes_addr : w == 2 ? mcu_addr : dcu_addr;
                  m_we    = w == 2 && mcu_we;
                  m_wdata = mcu_wdata;
                  if (w == 1) m_pend = 0;
                  if (w == 3) m_starve = 0;
                  else if (w == 2 && dcu_req) m_starve++;
               end
            end
         end
         @(posedge CLK or posedge RESET);
      end
   end

   int checks = 0, errors = 0, ncyc = 0;
   int n_snes_ack = 0, n_mcu_ack = 0, n_dcu_ack = 0, t_snes = 0, t_dcu = 0, we_low = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, ncyc);
      end
   endtask

   task automatic access(input int who, input logic we, input logic [AW-1:0] a,
                         input logic [15:0] d, output int lat);
      logic got;
      got = 1'b0;
      lat = 0;
      case (who)
         1:       begin snes_addr = a; snes_req = 1'b1; end
         2:       begin mcu_we = we; mcu_addr = a; mcu_wdata = d; mcu_req = 1'b1; end
         default: begin dcu_addr = a; dcu_req = 1'b1; end
      endcase
      while (!got && lat < 60) begin
         @(negedge CLK);
         lat++;
         got = who == 1 ? snes_ack : who == 2 ? mcu_ack : dcu_ack;
      end
      if (!got) chk($sformatf("ack_timeout_req%0d", who), 32'(got), 32'd1);
      if (who == 2) mcu_req = 1'b0;
      if (who == 3) dcu_req = 1'b0;
   endtask

   initial begin
      fork
         forever begin
            @(negedge CLK);
            ncyc++;
            if (snes_ack) begin n_snes_ack++; t_snes = ncyc; end
            if (dcu_ack)  begin n_dcu_ack++;  t_dcu  = ncyc; end
            if (mcu_ack)  n_mcu_ack++;
            if (!psram_we_n) we_low++;
            chk("busy",     32'(busy),       32'(m_t != 0));
            chk("ce_n",     32'(psram_ce_n), 32'(!(m_t >= 1 && m_t <= A + 1)));
            chk("oe_n",     32'(psram_oe_n), 32'(!(m_t >= 2 && m_t <= A + 1 && !m_we)));
            chk("we_n",     32'(psram_we_n), 32'(!(m_t >= 2 && m_t <= A + 1 && m_we)));
            chk("snes_ack", 32'(snes_ack),   32'(m_t == A + 2 && m_id == 1));
            chk("mcu_ack",  32'(mcu_ack),    32'(m_t == A + 2 && m_id == 2));
            chk("dcu_ack",  32'(dcu_ack),    32'(m_t == A + 2 && m_id == 3));
            chk("snes_rdata", 32'(snes_rdata), 32'(m_rd[1]));
            chk("mcu_rdata",  32'(mcu_rdata),  32'(m_rd[2]));
            chk("dcu_rdata",  32'(dcu_rdata),  32'(m_rd[3]));
            if (m_t > 0) chk("psram_addr", 32'(psram_addr), 32'(m_addr));
            if (m_t > 0 && m_we) chk("psram_wdata", 32'(psram_wdata), 32'(m_wdata));
         end
         begin
            int l1, l2, n0, m0;
            logic got;
            #1 RESET = 1'b1;
            repeat (2) @(negedge CLK);
            #2 RESET = 1'b0;
            @(negedge CLK);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_strobes", {29'd0, psram_ce_n, psram_oe_n, psram_we_n}, 32'd7);
            chk("rst_mcu_rdata", 32'(mcu_rdata), 32'd0);
            // MCU write then read-back
            we_low = 0;
            access(2, 1'b1, 23'h000010, 16'hBEEF, l1);
            @(negedge CLK);
            chk("mcu_wr_lat", l1, 6);
            chk("we_low_cycles", we_low, 4);
            access(2, 1'b0, 23'h000010, 16'h0000, l1);
            chk("mcu_rd_lat", l1, 6);
            chk("mcu_rd_beef", 32'(mcu_rdata), 32'h0000BEEF);
            @(negedge CLK);
            // SNES and DCU in the same cycle
            fork
               access(1, 1'b0, 23'h080000, 16'h0, l1);
               access(3, 1'b0, 23'h080100, 16'h0, l2);
            join
            snes_req = 1'b0;
            @(negedge CLK);
            chk("snes_first_lat", l1, 6);
            chk("dcu_after_snes", t_dcu - t_snes, 7);
            chk("snes_rd_080000", 32'(snes_rdata), 32'h0000A080);
            chk("dcu_rd_080100", 32'(dcu_rdata), 32'h0000A180);
            @(negedge CLK);
            // SNES trigger during the 2nd strobe cycle of a DCU access
            fork
               access(3, 1'b0, 23'h000200, 16'h0, l2);
               begin repeat (3) @(negedge CLK); access(1, 1'b0, 23'h080003, 16'h0, l1); end
            join
            snes_req = 1'b0;
            @(negedge CLK);
            chk("dcu_inflight_lat", l2, 6);
            chk("snes_trig_lat_le14", 32'(l1 <= 14), 32'd1);
            chk("snes_trig_lat", l1, 10);
            chk("snes_after_dcu", 32'(t_snes > t_dcu), 32'd1);
            chk("dcu_rd_200", 32'(dcu_rdata), 32'h0000A200);
            chk("snes_rd_080003", 32'(snes_rdata), 32'h0000A083);
            repeat (2) @(negedge CLK);
            // snes_req held high while the address steps
            n0 = n_snes_ack;
            access(1, 1'b0, 23'h080000, 16'h0, l1);
            access(1, 1'b0, 23'h080001, 16'h0, l2);
            chk("snes_step_lat", l2, 7);
            access(1, 1'b0, 23'h080002, 16'h0, l1);
            @(negedge CLK);
            chk("snes_step_acks", n_snes_ack - n0, 3);
            chk("snes_rd_080002", 32'(snes_rdata), 32'h0000A082);
            repeat (20) @(negedge CLK);
            chk("snes_no_extra", n_snes_ack - n0, 3);
            snes_req = 1'b0;
            repeat (2) @(negedge CLK);
            // async reset in the middle of an MCU write
            mcu_we = 1'b1; mcu_addr = 23'h000020; mcu_wdata = 16'h1234; mcu_req = 1'b1;
            m0 = n_mcu_ack;
            repeat (3) @(negedge CLK);
            chk("pre_rst_we_low", 32'(psram_we_n), 32'd0);
            #2 RESET = 1'b1;
            #1;
            chk("rst_mid_strobes", {29'd0, psram_ce_n, psram_oe_n, psram_we_n}, 32'd7);
            chk("rst_mid_busy", 32'(busy), 32'd0);
            mcu_req = 1'b0;
            repeat (3) @(negedge CLK);
            #2 RESET = 1'b0;
            @(negedge CLK);
            chk("rst_mid_no_ack", n_mcu_ack - m0, 0);
            access(2, 1'b0, 23'h000010, 16'h0, l1);
            chk("post_rst_lat", l1, 6);
            chk("post_rst_beef", 32'(mcu_rdata), 32'h0000BEEF);
            repeat (2) @(negedge CLK);
            // continuous MCU traffic with a waiting DCU
            mcu_we = 1'b0; mcu_addr = 23'h000010; mcu_req = 1'b1;
            dcu_addr = 23'h000200; dcu_req = 1'b1;
            m0 = n_mcu_ack;
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
               @(negedge CLK);
               got = dcu_ack;
            end
            if (GUARD) begin
               chk("starve_dcu_granted", 32'(got), 32'd1);
               chk("starve_mcu_before_dcu", n_mcu_ack - m0, 8);
            end else chk("nostarve_dcu_blocked", 32'(got), 32'd0);
            mcu_req = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
               @(negedge CLK);
               got = dcu_ack;
            end
            dcu_req = 1'b0;
            chk("dcu_served_eventually", 32'(got), 32'd1);
            repeat (12) @(negedge CLK);
            chk("final_idle", 32'(busy), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      join
   end
endmodule
